cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Shares the single common data bus (CDB) among the three result producers of the out-of-order core: the ALU reservation station, the branch unit and the store/load buffer. Each producer pushes (ROB entry, value) results into a small per-source queue. A round-robin scheduler grants at most one queue per cycle and drives a registered broadcast that the ROB, the reservation station and the store/load buffer all snoop. It replaces the current scheme of three independent CDB ports that every consumer must search in parallel.

## Interface
- `QUEUE_DEPTH`, 2: entries per source queue; must be at least 1.
- `clk_in` input 1: the single clock.
- `rst_in` input 1: reset, synchronous and active-high.
- `rdy_in` input 1: global enable. When low, all state freezes.
- `clear` input 1: flush on branch mispredict; same effect as reset.
- `alu_valid` input 1: ALU result offered.
- `alu_entry` input 5: destination ROB entry.
- `alu_value` input 32: result value.
- `alu_ready` output 1: ALU queue can accept.
- `br_valid`, `br_entry`, `br_value`, `br_ready`: same widths and meaning, branch source.
- `slb_valid`, `slb_entry`, `slb_value`, `slb_ready`: same widths and meaning, store/load source.
- `have_cdb` output 1: broadcast valid this cycle.
- `entry_cdb` output 5: broadcast ROB entry.
- `value_cdb` output 32: broadcast value.
- `src_cdb` output 2: producing source (0=ALU, 1=branch, 2=SLB).

## Operation
- Handshake: a result is accepted at a rising edge when `X_valid && X_ready && rdy_in && !clear && !rst_in`.
  - `X_ready` is `count_X < QUEUE_DEPTH`, taken from the registered count only; it never depends on `X_valid`.
  - A full queue reports not-ready even if it is being granted in that cycle.
- ROB entry 0 means "no dependency" and is reserved. A valid push with entry 0 is accepted and discarded: nothing is enqueued and nothing is broadcast.
- Each queue is FIFO. Results from one source are broadcast in acceptance order.
- Round-robin pointer `rr` takes values {0,1,2}.
  - Search order is rr, rr+1, rr+2 (mod 3); the first non-empty queue wins.
  - On a grant to source s: `rr <= (s+1) mod 3`.
  - With no grant, `rr` is unchanged.
- The granted head is popped. `have_cdb`, `entry_cdb`, `value_cdb` and `src_cdb` are registered from it.
- If no queue is non-empty, `have_cdb <= 0`; `entry_cdb`, `value_cdb` and `src_cdb` hold their last values.
- Enqueue and dequeue on the same queue in the same edge are both legal. The count is unchanged.
- `rdy_in` low: no accept, no grant. Queues, `rr` and all outputs hold. `X_ready` outputs are forced to 0.
- `rst_in` or `clear`:
  - empty all queues, `rr <= 0`;
  - `have_cdb <= 0`, `entry_cdb <= 0`, `value_cdb <= 0`, `src_cdb <= 0`;
  - inputs presented in the same cycle are dropped.
  - `clear` has priority over `rdy_in` low.

## Timing
- Reset values:
  - `have_cdb=0`, `entry_cdb=0`, `value_cdb=0`, `src_cdb=0`;
  - every `X_ready=1` in the first cycle after reset (with `rdy_in` high).
- Latency: a result accepted at edge t, if granted in the following cycle, is visible on the CDB in the cycle after edge t+1. There is no input-to-output bypass.
- Broadcast pulses last exactly one cycle per result (with `rdy_in` high).
- Throughput: one broadcast per cycle in total. Each source is guaranteed one grant in every 3 cycles while its queue is non-empty.
- Worst-case wait for a queue head is 2 cycles of arbitration.

## Structure
- Shared constants go in `define.v`: `SRC_ALU=2'd0`, `SRC_BR=2'd1`, `SRC_SLB=2'd2`.
- Sub-module `cdb_queue` holds the per-source circular FIFO and is instantiated 3 times.
  - Contents: `QUEUE_DEPTH` x 37-bit storage, head/tail pointers with wrap-around, and a count.
  - Ports: push, pop, flush, and outputs for count and head data.
  - The arbiter top holds `rr`, the grant logic and the output registers.

## Test plan
- Reset: hold `rst_in` 2 cycles, then release. Outputs are all 0, all three `X_ready=1`, `have_cdb` stays 0 with no valids.
- Single push: ALU pushes entry 5, value 0x12345678 at edge t. In the cycle after t+1: `have_cdb=1`, `entry_cdb=5`, `value_cdb=0x12345678`, `src_cdb=0`. The next cycle `have_cdb=0`.
- Contention: ALU, branch and SLB push entries 1, 2, 3 at the same edge with `rr=0`. Broadcasts are 1, 2, 3 on consecutive cycles with `src_cdb` 0, 1, 2, and `rr` ends at 0.
- Saturation (`QUEUE_DEPTH=2`): all three sources push every cycle with incrementing entries.
  - Each `X_ready` deasserts once its queue is full.
  - No entry is lost or duplicated, per-source order is preserved, and grants rotate strictly.
- Flush: two ALU results queued, `clear` pulsed for 1 cycle together with a new `br_valid`. Nothing is broadcast afterwards and all `X_ready=1`.
- Stall and reserved entry:
  - `rdy_in` low for 3 cycles with a broadcast of entry 7 pending. Outputs stay frozen, then the queue resumes in order.
  - A push with entry 0 is never broadcast.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants, types and helpers for the CDB arbiter and its queues.
package cdb_arbiter_pkg;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_BR  = 2'd1,
    SRC_SLB = 2'd2
  } src_e;

  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned ENTRY_W = 5;
  localparam int unsigned VALUE_W = 32;
  localparam int unsigned ITEM_W  = ENTRY_W + VALUE_W;

  typedef struct packed {
    logic [ENTRY_W-1:0] entry;
    logic [VALUE_W-1:0] value;
  } cdb_item_t;

  // (base + off) mod 3 for operands already in {0,1,2}.
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/cdb_arbiter_queue.sv
// Per-source circular FIFO of (ROB entry, value) results awaiting the CDB.
module cdb_queue
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                                 clk_in,
  input  logic                                 flush,
  input  logic                                 push,
  input  logic [ITEM_W-1:0]                    push_item,
  input  logic                                 pop,
  output logic [$clog2(QUEUE_DEPTH + 1)-1:0]   count,
  output logic [ITEM_W-1:0]                    head
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [ITEM_W-1:0] mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_in) begin
    if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= wrap_inc(tail_ptr);
      if (pop)  head_ptr <= wrap_inc(head_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && !flush) mem[tail_ptr] <= push_item;
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB broadcast among ALU, branch and SLB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        alu_valid,
  input  logic [4:0]  alu_entry,
  input  logic [31:0] alu_value,
  output logic        alu_ready,
  input  logic        br_valid,
  input  logic [4:0]  br_entry,
  input  logic [31:0] br_value,
  output logic        br_ready,
  input  logic        slb_valid,
  input  logic [4:0]  slb_entry,
  input  logic [31:0] slb_value,
  output logic        slb_ready,
  output logic        have_cdb,
  output logic [4:0]  entry_cdb,
  output logic [31:0] value_cdb,
  output logic [1:0]  src_cdb
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [NUM_SRC-1:0] in_valid;
  logic [NUM_SRC-1:0] in_ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] nonempty;
  logic [ENTRY_W-1:0] in_entry [NUM_SRC];
  logic [VALUE_W-1:0] in_value [NUM_SRC];
  logic [CNT_W-1:0]   count    [NUM_SRC];
  logic [ITEM_W-1:0]  head     [NUM_SRC];

  logic       flush;
  logic [1:0] rr;
  logic       grant_valid;
  logic [1:0] grant_src;
  logic [1:0] cand;
  cdb_item_t  granted;

  assign flush = rst_in || clear;

  assign in_valid = {slb_valid, br_valid, alu_valid};
  assign in_entry[SRC_ALU] = alu_entry;
  assign in_entry[SRC_BR]  = br_entry;
  assign in_entry[SRC_SLB] = slb_entry;
  assign in_value[SRC_ALU] = alu_value;
  assign in_value[SRC_BR]  = br_value;
  assign in_value[SRC_SLB] = slb_value;

  assign alu_ready = in_ready[SRC_ALU];
  assign br_ready  = in_ready[SRC_BR];
  assign slb_ready = in_ready[SRC_SLB];

  // Ready comes from the registered count only, so a full queue stays
  // not-ready even in a cycle where it is also being popped.
  always_comb begin
    in_ready = '0;
    nonempty = '0;
    push     = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      nonempty[s] = (count[s] != '0);
      in_ready[s] = rdy_in && (count[s] < CNT_W'(QUEUE_DEPTH));
      push[s]     = in_valid[s] && in_ready[s] && !flush && (in_entry[s] != '0);
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_src   = rr;
    cand        = rr;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = rr_add(rr, 2'(k));
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_src   = cand;
      end
    end
    if (!rdy_in || flush) grant_valid = 1'b0;
    pop = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      pop[s] = grant_valid && (grant_src == 2'(s));
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_queue
    cdb_queue #(
      .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
      .clk_in    (clk_in),
      .flush     (flush),
      .push      (push[g]),
      .push_item ({in_entry[g], in_value[g]}),
      .pop       (pop[g]),
      .count     (count[g]),
      .head      (head[g])
    );
  end

  assign granted = head[grant_src];

  always_ff @(posedge clk_in) begin
    if (flush) begin
      rr        <= '0;
      have_cdb  <= 1'b0;
      entry_cdb <= '0;
      value_cdb <= '0;
      src_cdb   <= '0;
    end else if (rdy_in) begin
      have_cdb <= grant_valid;
      if (grant_valid) begin
        entry_cdb <= granted.entry;
        value_cdb <= granted.value;
        src_cdb   <= grant_src;
        rr        <= rr_add(grant_src, 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Table-driven and scoreboard-checked bench for cdb_arbiter with QUEUE_DEPTH=2.
module tb_cdb_arbiter;

  localparam int DEPTH = 2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic [2:0]  vld;
  logic [4:0]  ent [3];
  logic [31:0] val [3];
  logic [2:0]  rdy_o;
  logic        have_cdb;
  logic [4:0]  entry_cdb;
  logic [31:0] value_cdb;
  logic [1:0]  src_cdb;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .clear     (clear),
    .alu_valid (vld[0]),
    .alu_entry (ent[0]),
    .alu_value (val[0]),
    .alu_ready (rdy_o[0]),
    .br_valid  (vld[1]),
    .br_entry  (ent[1]),
    .br_value  (val[1]),
    .br_ready  (rdy_o[1]),
    .slb_valid (vld[2]),
    .slb_entry (ent[2]),
    .slb_value (val[2]),
    .slb_ready (rdy_o[2]),
    .have_cdb  (have_cdb),
    .entry_cdb (entry_cdb),
    .value_cdb (value_cdb),
    .src_cdb   (src_cdb)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [4:0]  e;
    logic [31:0] v;
  } item_t;

  typedef struct packed {
    logic        rst;
    logic [2:0]  v;
    logic [4:0]  e0;
    logic [31:0] d0;
    logic [4:0]  e1;
    logic [31:0] d1;
    logic [4:0]  e2;
    logic [31:0] d2;
    logic        eh;
    logic [4:0]  ee;
    logic [31:0] ed;
    logic [1:0]  es;
    logic [2:0]  erdy;
  } vec_t;

  item_t q0[$], q1[$], q2[$], sb[$];
  int    n_vec = 0, n_err = 0;
  bit    m_valid = 1'b0;
  logic        m_have;
  logic [4:0]  m_entry;
  logic [31:0] m_value;
  logic [1:0]  m_src;
  int          m_rr;
  logic [2:0]  m_acc;
  int          n_acc [3];
  int          n_bc  [3];
  int          full_seen;
  vec_t        tab [20];
  vec_t        nov;
  int          cnt [3];

  function automatic int qsize(input int s);
    case (s)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic item_t qpop(input int s);
    case (s)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qpush(input int s, input item_t it);
    case (s)
      0:       q0.push_back(it);
      1:       q1.push_back(it);
      default: q2.push_back(it);
    endcase
  endfunction

  function automatic vec_t mk(input logic rst, input logic [2:0] v,
                              input logic [4:0] e0, input logic [31:0] d0,
                              input logic [4:0] e1, input logic [31:0] d1,
                              input logic [4:0] e2, input logic [31:0] d2,
                              input logic eh, input logic [4:0] ee,
                              input logic [31:0] ed, input logic [1:0] es);
    vec_t r;
    r.rst = rst; r.v = v;
    r.e0 = e0; r.d0 = d0; r.e1 = e1; r.d1 = d1; r.e2 = e2; r.d2 = d2;
    r.eh = eh; r.ee = ee; r.ed = ed; r.es = es; r.erdy = 3'b111;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] ae, input logic [31:0] ad,
                       input logic [4:0] be, input logic [31:0] bd,
                       input logic [4:0] ce, input logic [31:0] cd);
    vld = v;
    ent[0] = ae; val[0] = ad;
    ent[1] = be; val[1] = bd;
    ent[2] = ce; val[2] = cd;
  endtask

  // Behavioural reference: advances one clock edge using the inputs now driven.
  task automatic model_step();
    bit    found;
    int    gs;
    int    c;
    item_t it;
    m_acc = '0;
    if (rst_in || clear) begin
      q0.delete(); q1.delete(); q2.delete();
      m_rr = 0; m_have = 1'b0; m_entry = '0; m_value = '0; m_src = '0;
      m_valid = 1'b1;
    end else if (m_valid && rdy_in) begin
      for (int s = 0; s < 3; s++) m_acc[s] = vld[s] && (qsize(s) < DEPTH);
      found = 1'b0;
      gs = 0;
      for (int k = 0; k < 3; k++) begin
        c = (m_rr + k) % 3;
        if (!found && qsize(c) > 0) begin
          found = 1'b1;
          gs = c;
        end
      end
      if (found) begin
        it = qpop(gs);
        m_have = 1'b1; m_entry = it.e; m_value = it.v; m_src = it.src;
        m_rr = (gs + 1) % 3;
        sb.push_back(it);
      end else begin
        m_have = 1'b0;
      end
      for (int s = 0; s < 3; s++) begin
        if (m_acc[s] && ent[s] != 5'd0) begin
          it.src = 2'(s); it.e = ent[s]; it.v = val[s];
          qpush(s, it);
          n_acc[s]++;
        end
      end
    end
  endtask

  task automatic tick(input bit use_tab, input vec_t v);
    item_t it;
    @(negedge clk_in);
    if (m_valid) begin
      for (int s = 0; s < 3; s++) begin
        chk($sformatf("ready%0d", s), 32'(rdy_o[s]), 32'(rdy_in && (qsize(s) < DEPTH)));
        if (rdy_in && !rdy_o[s]) full_seen++;
      end
      if (use_tab) chk("tab_ready", 32'(rdy_o), 32'(v.erdy));
    end
    model_step();
    @(posedge clk_in);
    #1;
    if (m_valid) begin
      chk("have", 32'(have_cdb), 32'(m_have));
      chk("entry", 32'(entry_cdb), 32'(m_entry));
      chk("value", value_cdb, m_value);
      chk("src", 32'(src_cdb), 32'(m_src));
      if (have_cdb && rdy_in && !rst_in && !clear) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underflow: got broadcast entry %0h, want none at %0t", entry_cdb, $time);
        end else begin
          it = sb.pop_front();
          chk("sb_entry", 32'(entry_cdb), 32'(it.e));
          chk("sb_value", value_cdb, it.v);
          chk("sb_src", 32'(src_cdb), 32'(it.src));
          n_bc[it.src]++;
        end
      end
    end
    if (use_tab) begin
      chk("tab_have", 32'(have_cdb), 32'(v.eh));
      chk("tab_entry", 32'(entry_cdb), 32'(v.ee));
      chk("tab_value", value_cdb, v.ed);
      chk("tab_src", 32'(src_cdb), 32'(v.es));
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    nov = '0;
    full_seen = 0;
    for (int s = 0; s < 3; s++) begin n_acc[s] = 0; n_bc[s] = 0; cnt[s] = 0; end

    tab[0]  = mk(1, 3'b000,  0, 0,             0, 0,       0, 0,       0, 0, 0,             0);
    tab[1]  = mk(1, 3'b000,  0, 0,             0, 0,       0, 0,       0, 0, 0,             0);
    tab[2]  = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       0, 0, 0,             0);
    tab[3]  = mk(0, 3'b001,  5, 32'h12345678,  0, 0,       0, 0,       0, 0, 0,             0);
    tab[4]  = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       1, 5, 32'h12345678,  0);
    tab[5]  = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       0, 5, 32'h12345678,  0);
    tab[6]  = mk(0, 3'b100,  0, 0,             0, 0,       9, 32'h209, 0, 5, 32'h12345678,  0);
    tab[7]  = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       1, 9, 32'h209,       2);
    tab[8]  = mk(0, 3'b111,  1, 32'h11,        2, 32'h102, 3, 32'h203, 0, 9, 32'h209,       2);
    tab[9]  = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       1, 1, 32'h11,        0);
    tab[10] = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       1, 2, 32'h102,       1);
    tab[11] = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       1, 3, 32'h203,       2);
    tab[12] = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       0, 3, 32'h203,       2);
    tab[13] = mk(0, 3'b111,  4, 32'h44,        6, 32'h66,  7, 32'h77,  0, 3, 32'h203,       2);
    tab[14] = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       1, 4, 32'h44,        0);
    tab[15] = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       1, 6, 32'h66,        1);
    tab[16] = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       1, 7, 32'h77,        2);
    tab[17] = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       0, 7, 32'h77,        2);
    tab[18] = mk(0, 3'b001,  0, 32'hDEAD,      0, 0,       0, 0,       0, 7, 32'h77,        2);
    tab[19] = mk(0, 3'b000,  0, 0,             0, 0,       0, 0,       0, 7, 32'h77,        2);

    // Reset, single push latency, contention from rr=0 twice, reserved entry 0.
    for (int i = 0; i < 20; i++) begin
      rst_in = tab[i].rst;
      clear  = 1'b0;
      rdy_in = 1'b1;
      drive(tab[i].v, tab[i].e0, tab[i].d0, tab[i].e1, tab[i].d1, tab[i].e2, tab[i].d2);
      tick(1'b1, tab[i]);
    end

    // Flush with two ALU results queued and a branch push dropped on the clear edge.
    drive(3'b011, 10, 32'hA0, 20, 32'hB0, 0, 0);  tick(1'b0, nov);
    drive(3'b001, 11, 32'hA1, 0, 0, 0, 0);        tick(1'b0, nov);
    drive(3'b001, 12, 32'hA2, 0, 0, 0, 0);        tick(1'b0, nov);
    clear = 1'b1;
    drive(3'b010, 0, 0, 22, 32'hB2, 0, 0);        tick(1'b0, nov);
    clear = 1'b0;
    chk("flush_have", 32'(have_cdb), 32'd0);
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    repeat (4) tick(1'b0, nov);
    chk("flush_idle", 32'(have_cdb), 32'd0);
    chk("flush_ready", 32'(rdy_o), 32'd7);

    // Stall with a broadcast on the bus and entry 7 still queued.
    drive(3'b101, 8, 32'h888, 0, 0, 7, 32'h777);  tick(1'b0, nov);
    drive(3'b000, 0, 0, 0, 0, 0, 0);              tick(1'b0, nov);
    rdy_in = 1'b0;
    drive(3'b001, 9, 32'h999, 0, 0, 0, 0);
    repeat (3) tick(1'b0, nov);
    chk("stall_have", 32'(have_cdb), 32'd1);
    chk("stall_entry", 32'(entry_cdb), 32'd8);
    chk("stall_ready", 32'(rdy_o), 32'd0);
    rdy_in = 1'b1;
    tick(1'b0, nov);
    chk("resume_entry", 32'(entry_cdb), 32'd7);
    chk("resume_src", 32'(src_cdb), 32'd2);
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    repeat (3) tick(1'b0, nov);

    // Saturation: every source offers a new result each cycle, held until accepted.
    full_seen = 0;
    for (int s = 0; s < 3; s++) begin n_acc[s] = 0; n_bc[s] = 0; end
    repeat (30) begin
      vld = 3'b111;
      for (int s = 0; s < 3; s++) begin
        ent[s] = 5'((cnt[s] % 31) + 1);
        val[s] = (32'(s) << 28) | 32'(cnt[s]);
      end
      tick(1'b0, nov);
      for (int s = 0; s < 3; s++) if (m_acc[s]) cnt[s]++;
    end
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    repeat (10) tick(1'b0, nov);
    chk("sat_full_seen", 32'(full_seen > 0), 32'd1);
    for (int s = 0; s < 3; s++) chk($sformatf("sat_count%0d", s), 32'(n_bc[s]), 32'(n_acc[s]));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
